// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles, branch squash,
// data-memory wait freeze with watchdog. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_control_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 64
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W             = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic [4:0] ID_EX_Rt,
    input  logic       ID_EX_MemRead,
    input  logic       PCSrc,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       ID_EX_Write,
    output logic       EX_MEM_Write,
    output logic       MEM_WB_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       MEM_WB_Flush,
    output logic       mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`else
    output logic [1:0] state
`endif
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2,
        StError     = 2'd3
    } state_e;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_EXT = (WAIT_W + 1)'(MEM_TIMEOUT);
    localparam logic [2:0] LOAD_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        load_cnt_q, load_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W:0]   wait_inc;
    logic              load_use, mem_freeze, run_eval;
    logic              do_freeze, do_branch, do_bubble;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
    assign mem_freeze = mem_req && !mem_ready;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        wait_cnt_d = wait_cnt_q;
        wait_inc   = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);
        run_eval   = 1'b0;
        do_freeze  = 1'b0;
        do_branch  = 1'b0;
        do_bubble  = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_freeze) begin
                    do_freeze  = 1'b1;
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = (MEM_TIMEOUT == 1) ? StError : StMemWait;
                end else begin
                    run_eval = 1'b1;
                end
            end
            StLoadStall: begin
                if (mem_freeze) begin
                    do_freeze  = 1'b1;
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = (MEM_TIMEOUT == 1) ? StError : StMemWait;
                end else if (PCSrc) begin
                    do_branch = 1'b1;
                    state_d   = StRun;
                end else begin
                    do_bubble  = 1'b1;
                    load_cnt_d = load_cnt_q - 3'd1;
                    if (load_cnt_q == 3'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    do_freeze = 1'b1;
                    if (MEM_TIMEOUT != 0) begin
                        if (wait_inc >= TIMEOUT_EXT) begin
                            wait_cnt_d = TIMEOUT_EXT[WAIT_W-1:0];
                            state_d    = StError;
                        end else begin
                            wait_cnt_d = wait_inc[WAIT_W-1:0];
                        end
                    end
                end else begin
                    // Release cycle: behave as RUN with mem_req ignored.
                    run_eval = 1'b1;
                end
            end
            StError: begin
            end
            default: begin
            end
        endcase

        if (run_eval) begin
            state_d = StRun;
            if (PCSrc) begin
                do_branch = 1'b1;
            end else if (load_use) begin
                do_bubble = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d    = StLoadStall;
                    load_cnt_d = LOAD_INIT;
                end
            end
        end

        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (state_q == StError) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (do_freeze) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (do_branch) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (do_bubble) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            load_cnt_q <= 3'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ERROR is only left through reset, so the flag is sticky by construction.
    assign mem_timeout = (state_q == StError);
    assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Branch squash is the only source of IF_ID_Flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PCWrite && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (IF_ID_Flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: dut_a uses default parameters, dut_b uses a 3-cycle load stall and a
// 4-cycle memory watchdog; both see the same stimulus.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] if_rs, if_rt, ex_rt;
    logic       memrd, pcsrc, req, rdy;

    logic [4:0] wr_a, wr_b;
    logic [3:0] fl_a, fl_b;
    logic [1:0] st_a, st_b;
    logic       mt_a, mt_b;
    logic [11:0] obs_a, obs_b;

    int unsigned total;
    int unsigned passed;
    int unsigned failed;

    localparam logic [4:0] W_ALL  = 5'b11111;
    localparam logic [4:0] W_BUB  = 5'b00111;
    localparam logic [4:0] W_NONE = 5'b00000;
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_BUB  = 4'b0100;
    localparam logic [3:0] F_BR   = 4'b1110;
    localparam logic [3:0] F_MEM  = 4'b0001;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .ID_EX_Rt(ex_rt),
        .ID_EX_MemRead(memrd), .PCSrc(pcsrc), .mem_req(req), .mem_ready(rdy),
        .PCWrite(wr_a[4]), .IF_ID_Write(wr_a[3]), .ID_EX_Write(wr_a[2]),
        .EX_MEM_Write(wr_a[1]), .MEM_WB_Write(wr_a[0]),
        .IF_ID_Flush(fl_a[3]), .ID_EX_Flush(fl_a[2]), .EX_MEM_Flush(fl_a[1]),
        .MEM_WB_Flush(fl_a[0]), .mem_timeout(mt_a), .state(st_a),
        .stall_cycles(stall_a), .flush_events(flush_a)
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .ID_EX_Rt(ex_rt),
        .ID_EX_MemRead(memrd), .PCSrc(pcsrc), .mem_req(req), .mem_ready(rdy),
        .PCWrite(wr_b[4]), .IF_ID_Write(wr_b[3]), .ID_EX_Write(wr_b[2]),
        .EX_MEM_Write(wr_b[1]), .MEM_WB_Write(wr_b[0]),
        .IF_ID_Flush(fl_b[3]), .ID_EX_Flush(fl_b[2]), .EX_MEM_Flush(fl_b[1]),
        .MEM_WB_Flush(fl_b[0]), .mem_timeout(mt_b), .state(st_b),
        .stall_cycles(stall_b), .flush_events(flush_b)
    );
`else
    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .ID_EX_Rt(ex_rt),
        .ID_EX_MemRead(memrd), .PCSrc(pcsrc), .mem_req(req), .mem_ready(rdy),
        .PCWrite(wr_a[4]), .IF_ID_Write(wr_a[3]), .ID_EX_Write(wr_a[2]),
        .EX_MEM_Write(wr_a[1]), .MEM_WB_Write(wr_a[0]),
        .IF_ID_Flush(fl_a[3]), .ID_EX_Flush(fl_a[2]), .EX_MEM_Flush(fl_a[1]),
        .MEM_WB_Flush(fl_a[0]), .mem_timeout(mt_a), .state(st_a)
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .ID_EX_Rt(ex_rt),
        .ID_EX_MemRead(memrd), .PCSrc(pcsrc), .mem_req(req), .mem_ready(rdy),
        .PCWrite(wr_b[4]), .IF_ID_Write(wr_b[3]), .ID_EX_Write(wr_b[2]),
        .EX_MEM_Write(wr_b[1]), .MEM_WB_Write(wr_b[0]),
        .IF_ID_Flush(fl_b[3]), .ID_EX_Flush(fl_b[2]), .EX_MEM_Flush(fl_b[1]),
        .MEM_WB_Flush(fl_b[0]), .mem_timeout(mt_b), .state(st_b)
    );
`endif

    assign obs_a = {wr_a, fl_a, st_a, mt_a};
    assign obs_b = {wr_b, fl_b, st_b, mt_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input logic [4:0] w, input logic [3:0] f,
                                       input logic [1:0] s, input logic m);
        return {w, f, s, m};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                         input logic mr, input logic pc, input logic rq, input logic rd);
        if_rs = rs;
        if_rt = rt;
        ex_rt = xrt;
        memrd = mr;
        pcsrc = pc;
        req   = rq;
        rdy   = rd;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n  = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_a", obs_a, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        chk("rst_b", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        @(negedge clk) rst_n = 1'b1;

        // Load-use on rs: single bubble in a, three bubbles in b.
        @(negedge clk) drive(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_a", obs_a, pk(W_BUB, F_BUB, 2'd0, 1'b0));
        chk("lu_b_bub1", obs_b, pk(W_BUB, F_BUB, 2'd0, 1'b0));
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_a_after", obs_a, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        chk("lu_b_bub2", obs_b, pk(W_BUB, F_BUB, 2'd1, 1'b0));
        @(negedge clk) #1;
        chk("lu_b_bub3", obs_b, pk(W_BUB, F_BUB, 2'd1, 1'b0));
        @(negedge clk) #1;
        chk("lu_b_done", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));

        // Load into $0 never stalls.
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("r0_a", obs_a, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        chk("r0_b", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));

        // Load-use on rt, then a branch aborts b's stall in its second bubble.
        @(negedge clk) drive(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_rt_a", obs_a, pk(W_BUB, F_BUB, 2'd0, 1'b0));
        chk("lu_rt_b", obs_b, pk(W_BUB, F_BUB, 2'd0, 1'b0));
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_a", obs_a, pk(W_ALL, F_BR, 2'd0, 1'b0));
        chk("abort_b", obs_b, pk(W_ALL, F_BR, 2'd1, 1'b0));
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("abort_b_run", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));

        // Branch beats a simultaneous load-use.
        @(negedge clk) drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_lu_a", obs_a, pk(W_ALL, F_BR, 2'd0, 1'b0));
        chk("br_lu_b", obs_b, pk(W_ALL, F_BR, 2'd0, 1'b0));
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("br_after_a", obs_a, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        chk("br_after_b", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));

        // Five wait cycles; b's watchdog trips after four.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            chk($sformatf("memw_a_%0d", i), obs_a,
                pk(W_NONE, F_MEM, (i == 0) ? 2'd0 : 2'd2, 1'b0));
            chk($sformatf("memw_b_%0d", i), obs_b,
                (i < 4) ? pk(W_NONE, F_MEM, (i == 0) ? 2'd0 : 2'd2, 1'b0)
                        : pk(W_NONE, F_NONE, 2'd3, 1'b1));
        end
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("release_a", obs_a, pk(W_ALL, F_NONE, 2'd2, 1'b0));
        chk("release_err_b", obs_b, pk(W_NONE, F_NONE, 2'd3, 1'b1));
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_release_a", obs_a, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        chk("sticky_err_b", obs_b, pk(W_NONE, F_NONE, 2'd3, 1'b1));

        // Asynchronous reset out of ERROR.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_err_b", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset in the middle of b's load stall.
        @(negedge clk) drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("ls_b", obs_b, pk(W_BUB, F_BUB, 2'd1, 1'b0));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ls_b", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) #1;
        chk("no_resume_b", obs_b, pk(W_ALL, F_NONE, 2'd0, 1'b0));

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_cnt_a", 12'(flush_a), 12'd2);
        chk("flush_cnt_b", 12'(flush_b), 12'd2);
        chk("stall_zero_b", 12'(stall_b), 12'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_cnt_a", 12'(stall_a), 12'd20);
        chk("stall_sat_b", 12'(stall_b), 12'd15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core; it fills the hazard-unit slot next to the forwarding unit.
- The forwarding unit resolves data hazards by steering operand muxes. This block resolves the hazards forwarding cannot fix: load-use, taken-branch squash and multi-cycle data-memory waits.
- It does this by driving the write-enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- It is sequential: a stall state machine, a load-stall counter and a memory-timeout watchdog.

Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; range 1..7.
- MEM_TIMEOUT, 64: maximum consecutive mem-wait cycles before the error state; 0 disables the watchdog.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_ID_Rs  in  5  rs field of the instruction in ID
- IF_ID_Rt  in  5  rt field of the instruction in ID
- ID_EX_Rt  in  5  destination (rt) of the instruction in EX
- ID_EX_MemRead  in  1  instruction in EX is a load
- PCSrc  in  1  taken branch resolved in MEM
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1 each  register write enables
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush  out  1 each  synchronous bubble insert
- mem_timeout  out  1  sticky watchdog error
- state  out  2  current FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT, 3 ERROR

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; load counter and wait counter cleared; mem_timeout=0.
  - Outputs take their RUN values: all Write=1, all Flush=0.
- Outputs are Mealy: computed from state and the current inputs, so every stall or flush acts in the same cycle the hazard is seen.
- Load-use hazard: ID_EX_MemRead=1, ID_EX_Rt!=0, and ID_EX_Rt equals IF_ID_Rs or IF_ID_Rt. Register 0 never stalls.
- Priority in every cycle: memory freeze > branch flush > load-use stall.
- RUN:
  - mem_req=1 and mem_ready=0: all five Write=0 and MEM_WB_Flush=1. Go to MEM_WAIT, wait counter=1.
  - Else if PCSrc=1: IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1; PCWrite=1. Stay in RUN.
  - Else if load-use: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with counter=LOAD_STALL_CYCLES-1.
  - Else: all Write=1, all Flush=0.
- LOAD_STALL:
  - Each cycle: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; counter decrements.
  - Counter reaching 0 returns the FSM to RUN.
  - PCSrc=1 aborts the stall: apply the branch flush with PCWrite=1, then go to RUN.
  - mem_req=1 with mem_ready=0 overrides: go to MEM_WAIT.
- MEM_WAIT:
  - mem_ready=0: freeze as on entry; wait counter increments, saturating at MEM_TIMEOUT.
  - When the counter equals MEM_TIMEOUT (and MEM_TIMEOUT!=0): go to ERROR.
  - mem_ready=1 (release cycle): outputs are evaluated exactly as in RUN with mem_req ignored, so a load-use in this cycle stalls normally. Go to RUN, or LOAD_STALL if the multi-cycle load-stall rule applies.
  - Load-use and PCSrc are not acted on while frozen; they are re-evaluated in the release cycle.
- ERROR:
  - All Write=0 and all Flush=0; mem_timeout=1.
  - Exit only through reset.
- mem_req=1 with PCSrc=1 in the same cycle is illegal (both come from the single MEM instruction). The memory freeze wins.
- Reset asserted mid-stall: returns to RUN immediately, asynchronously; the remaining stall count is discarded.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0] and flush_events[CNT_W-1:0].
  - stall_cycles increments on every cycle with PCWrite=0.
  - flush_events increments on every cycle a PCSrc flush is applied.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: lw $8 in EX (ID_EX_MemRead=1, ID_EX_Rt=8), IF_ID_Rs=8 -> one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle all Write=1. Repeat with ID_EX_Rt=0 -> no stall.
- LOAD_STALL_CYCLES=3 with a load-use -> exactly 3 consecutive bubble cycles, state=1 for 2 of them. PCSrc=1 in the 2nd bubble -> flush of IF/ID, ID/EX, EX/MEM with PCWrite=1, state=0 next cycle.
- Taken branch: PCSrc=1 in RUN -> IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1 for one cycle and PCWrite=1; a simultaneous load-use is ignored.
- Memory wait: mem_req=1, mem_ready low for 5 cycles, then high -> 5 cycles with all Write=0 and MEM_WB_Flush=1; release cycle has all Write=1; state returns to 0.
- Watchdog: MEM_TIMEOUT=4, mem_ready held at 0 -> state=3 and mem_timeout=1 after 4 wait cycles. Asserting rst_n=0 mid-ERROR -> state=0 and mem_timeout=0 immediately.
- With HAZARD_PERF_CNT_EN defined, CNT_W=4: 20 stall cycles -> stall_cycles saturates at 15.
